// File: rtl/multi_syncer_edge_det_pkg.sv
// general_syncer_pkg: edge-select encodings and counter-width helper shared by the syncer block.
package general_syncer_pkg;
  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/multi_syncer_edge_det_if.sv
// multi_syncer_edge_det_if: level inputs, edge selects and filtered outputs of the syncer block.
interface multi_syncer_edge_det_if #(parameter int CH_NUM = 4);
  logic [CH_NUM-1:0]   data_unsync_i;
  logic [2*CH_NUM-1:0] edge_sel_i;
  logic [CH_NUM-1:0]   evt_clr_i;
  logic [CH_NUM-1:0]   level_o;
  logic [CH_NUM-1:0]   rise_o;
  logic [CH_NUM-1:0]   fall_o;
  logic [CH_NUM-1:0]   edge_o;
  logic [CH_NUM-1:0]   evt_flag_o;
  modport master (output data_unsync_i, edge_sel_i, evt_clr_i,
                  input  level_o, rise_o, fall_o, edge_o, evt_flag_o);
  modport slave  (input  data_unsync_i, edge_sel_i, evt_clr_i,
                  output level_o, rise_o, fall_o, edge_o, evt_flag_o);
endinterface

// File: rtl/multi_syncer_edge_det_filter_ch.sv
// syncer_filter_ch: one channel's sync chain, persistence filter, edge pulses and (STICKY_EVENT_EN) sticky flag.
module syncer_filter_ch
  import general_syncer_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       data_i,
  input  logic [1:0] edge_sel_i,
  input  logic       evt_clr_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       edge_o,
  output logic       evt_flag_o
);
  localparam int CW = clog2(FILT_LEN + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sync_v;
  logic                   upd;
  assign sync_v = sync_q[SYNC_STAGES-1];
  // level follows only after FILT_LEN consecutive disagreeing samples
  assign upd = (sync_v != level_o) && (cnt_q == CW'(FILT_LEN - 1));
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      cnt_q   <= '0;
      level_o <= RST_VAL;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      edge_o  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], data_i};
      cnt_q   <= (sync_v == level_o || upd) ? '0 : cnt_q + 1'b1;
      level_o <= upd ? sync_v : level_o;
      rise_o  <= upd & sync_v;
      fall_o  <= upd & ~sync_v;
      edge_o  <= upd && ((edge_sel_i & (sync_v ? EDGE_RISE : EDGE_FALL)) != EDGE_NONE);
    end
  end
`ifdef STICKY_EVENT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) evt_flag_o <= 1'b0;
    else          evt_flag_o <= edge_o | (evt_flag_o & ~evt_clr_i);
  end
`else
  logic unused_clr;
  assign unused_clr = evt_clr_i;
  assign evt_flag_o = 1'b0;
`endif
endmodule

// File: rtl/multi_syncer_edge_det.sv
// multi_syncer_edge_det: CH_NUM independent async-level synchronisers with glitch filter and edge pulses.
// Optional sticky event flags are built when STICKY_EVENT_EN is defined.
module multi_syncer_edge_det #(
  parameter int              CH_NUM      = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_LEN    = 4,
  parameter logic [CH_NUM-1:0] RST_VAL   = '0
) (
  input logic                     clk_i,
  input logic                     rst_n_i,
  multi_syncer_edge_det_if.slave  bus
);
  logic [CH_NUM-1:0] level, rise, fall, edg, flag;
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    syncer_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .RST_VAL    (RST_VAL[c])
    ) u_ch (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .data_i    (bus.data_unsync_i[c]),
      .edge_sel_i(bus.edge_sel_i[2*c+:2]),
      .evt_clr_i (bus.evt_clr_i[c]),
      .level_o   (level[c]),
      .rise_o    (rise[c]),
      .fall_o    (fall[c]),
      .edge_o    (edg[c]),
      .evt_flag_o(flag[c])
    );
  end
  assign bus.level_o    = level;
  assign bus.rise_o     = rise;
  assign bus.fall_o     = fall;
  assign bus.edge_o     = edg;
  assign bus.evt_flag_o = flag;
endmodule

// File: tb/tb_multi_syncer_edge_det.sv
// tb_multi_syncer_edge_det: directed + random stimulus against a queue-based reference model with a scoreboard.
module tb_multi_syncer_edge_det;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FL = 4;
  localparam logic [CH-1:0] RV = '0;

  typedef struct packed {
    logic [CH-1:0] level, rise, fall, edg, flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_syncer_edge_det_if #(.CH_NUM(CH)) bus ();
  multi_syncer_edge_det #(.CH_NUM(CH), .SYNC_STAGES(SS), .FILT_LEN(FL), .RST_VAL(RV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  // reference model: delay line of raw samples, and the run of synced samples since the last level change
  bit dl[CH][$];
  bit pr[CH][$];
  logic [CH-1:0] m_lvl, m_rise, m_fall, m_edge, m_flag;
  logic [CH-1:0] rst_val;

  function automatic exp_t got();
    return '{bus.level_o, bus.rise_o, bus.fall_o, bus.edge_o, bus.evt_flag_o};
  endfunction

  function automatic exp_t reset_exp();
    return '{rst_val, '0, '0, '0, '0};
  endfunction

  task automatic check(input string name, input exp_t e, input exp_t a);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s t=%0t lvl/rise/fall/edge/flag got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h",
               name, $time, a.level, a.rise, a.fall, a.edg, a.flag,
               e.level, e.rise, e.fall, e.edg, e.flag);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      dl[c].delete();
      pr[c].delete();
      for (int i = 0; i < SS; i++) dl[c].push_back(rst_val[c]);
    end
    m_lvl = rst_val; m_rise = '0; m_fall = '0; m_edge = '0; m_flag = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] d, input logic [2*CH-1:0] s, input logic [CH-1:0] k);
    logic [CH-1:0] nflag;
    bit v, upd;
`ifdef STICKY_EVENT_EN
    nflag = m_edge | (m_flag & ~k);
`else
    nflag = '0;
`endif
    for (int c = 0; c < CH; c++) begin
      v = dl[c].pop_front();
      dl[c].push_back(d[c]);
      pr[c].push_back(v);
      if (pr[c].size() > FL) void'(pr[c].pop_front());
      upd = (pr[c].size() == FL);
      foreach (pr[c][i]) if (pr[c][i] == m_lvl[c]) upd = 0;
      m_rise[c] = upd && v;
      m_fall[c] = upd && !v;
      m_edge[c] = upd && (v ? s[2*c] : s[2*c+1]);
      if (upd) begin
        m_lvl[c] = v;
        pr[c].delete();
      end
    end
    m_flag = nflag;
  endtask

  task automatic cyc(input logic [CH-1:0] d, input logic [2*CH-1:0] s, input logic [CH-1:0] k);
    bus.data_unsync_i = d; bus.edge_sel_i = s; bus.evt_clr_i = k;
    @(posedge clk);
    model_step(d, s, k);
    sb.push_back('{m_lvl, m_rise, m_fall, m_edge, m_flag});
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", reset_exp(), got());
    model_reset();
    repeat (2) begin
      @(posedge clk);
      sb.push_back(reset_exp());
    end
    #1 rst_n = 1'b1;
  endtask

  // monitor: every cycle the DUT presents a registered output set
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) check("scoreboard", sb.pop_front(), got());
  end

  initial begin
    logic [CH-1:0] d, k;
    logic [2*CH-1:0] s;
    int hold[CH];
    rst_val = RV;
    model_reset();
    bus.data_unsync_i = 4'hF; bus.edge_sel_i = 8'hFF; bus.evt_clr_i = '0;
    repeat (2) begin
      @(posedge clk);
      sb.push_back(reset_exp());
    end
    #1 rst_n = 1'b1;
    repeat (10) cyc(4'hF, 8'h55, 4'h0);
    repeat (8) cyc(4'h0, 8'hFF, 4'h0);
    repeat (3) cyc(4'h1, 8'hFF, 4'h0);
    repeat (8) cyc(4'h0, 8'hFF, 4'h0);
    repeat (10) cyc(4'h2, 8'hBB, 4'h0);
    repeat (10) cyc(4'h0, 8'hBB, 4'h0);
    for (int i = 0; i < 36; i++) cyc(((i / 6) % 2) ? 4'h4 : 4'h0, 8'hFF, 4'h0);
    repeat (10) cyc(4'h8, 8'hFF, 4'h0);
    repeat (4) cyc(4'h0, 8'hFF, 4'h0);
    do_reset();
    repeat (8) cyc(4'h0, 8'hFF, 4'h0);
    repeat (8) cyc(4'h1, 8'hFF, 4'hF);
    repeat (4) cyc(4'h1, 8'hFF, 4'h0);
    cyc(4'h1, 8'hFF, 4'h1);
    repeat (3) cyc(4'h1, 8'hFF, 4'h0);
    d = '0;
    for (int c = 0; c < CH; c++) hold[c] = 1;
    s = 8'hE4;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          d[c] = ~d[c];
          hold[c] = $urandom_range(1, 9);
        end
      end
      if ($urandom_range(0, 15) == 0) s = 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      cyc(d, s, k);
      if (n == 700 || n == 1400) do_reset();
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain leftover=%0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
